mcpu_ctrl_ws: RTL and testbench

Parametrised multicycle control unit for the mcpu datapath, replacing the fixed-timing controller with one that handshakes with a variable-latency memory. It sequences IF/ID/EXE/MEM/WB per opcode, stretches fetch and memory states until `mem_ready`, and traps to an error state on memory timeout or illegal opcode. It also keeps a saturating retired-instruction counter and a terminal halt state for bench-controlled end of program.

---
 rtl/mcpu_ctrl_ws.sv | 198 +++++++++++++++++++
 tb/tb_mcpu_ctrl_ws.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl_ws.sv
// mcpu_ctrl_ws: multicycle control unit for the mcpu datapath, with a
// handshake to a variable-latency memory.
//
// Sequences IF/ID/EXE/MEM/WB per opcode. IF and MEM are held until mem_ready
// is seen. The controller traps to ERR on a memory timeout or an illegal
// opcode, and goes to HALT on HALT_OP. It also keeps a saturating count of
// retired instructions.
//
// state | meaning
// ------+-------------------------------------------------------------
// IF    | fetch: request memory, load IR and PC+4 on mem_ready
// ID    | decode: branch target precompute, j completes here
// EXE   | execute: ALU op per opcode, beq completes here
// MEM   | lw/sw memory access, held until mem_ready
// WB    | register write-back
// HALT  | end of program, absorbing until Reset
// ERR   | timeout or illegal opcode, absorbing until Reset
//
// Ports:
//   clk, Reset              clock, asynchronous active-high reset
//   opcode, zero, mem_ready IR[31:26], ALU zero flag, memory completion
//   state_out               current state code (IF=0 .. ERR=6)
//   mem_req, mem_we         memory request / write enable
//   ir_write, pc_write, reg_write, reg_dst, mem_to_reg  datapath strobes
//   pc_src, alu_src_b, alu_op                           datapath selects
//   halted, fault           high in HALT / ERR
//   retired                 saturating retired-instruction count
module mcpu_ctrl_ws #(
  parameter int          CNT_W   = 32,
  parameter int          TIMEOUT = 15,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state_out,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Wide enough to hold TIMEOUT itself; with the timeout disabled the
  // counter is irrelevant and one bit is kept to stay legal.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire;
  logic              timeout_hit;
  logic              op_to_exe;

  // mem_ready wins over the limit: this is only consulted when ready is low.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TIMEOUT_W);
  assign op_to_exe   = (opcode == OP_R)  || (opcode == OP_ADDI) ||
                       (opcode == OP_LW) || (opcode == OP_SW)   ||
                       (opcode == OP_BEQ);
  assign state_out   = state;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IF;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || mem_ready)
        wait_cnt <= '0;
      else if (((state == S_IF) || (state == S_MEM)) && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 1'b1;
      if (retire && (retired != '1))
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'b00;
    halted     = 1'b0;
    fault      = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IF: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_ID;
        end else if (timeout_hit) begin
          next_state = S_ERR;
        end
      end
      S_ID: begin
        alu_src_b = 2'd3;
        if (opcode == HALT_OP) begin
          next_state = S_HALT;
        end else if (opcode == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          retire     = 1'b1;
          next_state = S_IF;
        end else if (op_to_exe) begin
          next_state = S_EXE;
        end else begin
          next_state = S_ERR;
        end
      end
      S_EXE: begin
        case (opcode)
          OP_R: begin
            alu_op     = 2'b10;
            next_state = S_WB;
          end
          OP_ADDI: begin
            alu_src_b  = 2'd2;
            next_state = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b  = 2'd2;
            next_state = S_MEM;
          end
          OP_BEQ: begin
            alu_op     = 2'b01;
            pc_src     = 2'd1;
            pc_write   = zero;
            retire     = 1'b1;
            next_state = S_IF;
          end
          default: next_state = S_ERR;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire     = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_WB;
          end
        end else if (timeout_hit) begin
          next_state = S_ERR;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_R);
        mem_to_reg = (opcode == OP_LW);
        retire     = 1'b1;
        next_state = S_IF;
      end
      S_HALT: halted = 1'b1;
      S_ERR:  fault  = 1'b1;
      default: next_state = S_ERR;
    endcase
  end

endmodule

// File: tb/tb_mcpu_ctrl_ws.sv
module tb_mcpu_ctrl_ws;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_ILL  = 6'b010101;
  localparam int TMO = 15;

  logic clk, Reset, zero, mem_ready;
  logic [5:0] opcode;

  logic [2:0]  m_state, n_state, s_state;
  logic        m_mreq, m_mwe, m_irw, m_pcw, m_rw, m_rdst, m_m2r, m_hlt, m_flt;
  logic        n_mreq, n_mwe, n_irw, n_pcw, n_rw, n_rdst, n_m2r, n_hlt, n_flt;
  logic        s_mreq, s_mwe, s_irw, s_pcw, s_rw, s_rdst, s_m2r, s_hlt, s_flt;
  logic [1:0]  m_pcs, m_asb, m_aop, n_pcs, n_asb, n_aop, s_pcs, s_asb, s_aop;
  logic [31:0] m_ret, n_ret;
  logic [2:0]  s_ret;
  logic [14:0] m_outs;

  assign m_outs = {m_mreq, m_mwe, m_irw, m_pcw, m_rw, m_rdst, m_m2r,
                   m_pcs, m_asb, m_aop, m_hlt, m_flt};

  mcpu_ctrl_ws u_dut (
    .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state_out(m_state), .mem_req(m_mreq), .mem_we(m_mwe), .ir_write(m_irw),
    .pc_write(m_pcw), .reg_write(m_rw), .reg_dst(m_rdst), .mem_to_reg(m_m2r),
    .pc_src(m_pcs), .alu_src_b(m_asb), .alu_op(m_aop), .halted(m_hlt),
    .fault(m_flt), .retired(m_ret));

  mcpu_ctrl_ws #(.TIMEOUT(0)) u_dut_nt (
    .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state_out(n_state), .mem_req(n_mreq), .mem_we(n_mwe), .ir_write(n_irw),
    .pc_write(n_pcw), .reg_write(n_rw), .reg_dst(n_rdst), .mem_to_reg(n_m2r),
    .pc_src(n_pcs), .alu_src_b(n_asb), .alu_op(n_aop), .halted(n_hlt),
    .fault(n_flt), .retired(n_ret));

  mcpu_ctrl_ws #(.CNT_W(3)) u_dut_sat (
    .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state_out(s_state), .mem_req(s_mreq), .mem_we(s_mwe), .ir_write(s_irw),
    .pc_write(s_pcw), .reg_write(s_rw), .reg_dst(s_rdst), .mem_to_reg(s_m2r),
    .pc_src(s_pcs), .alu_src_b(s_asb), .alu_op(s_aop), .halted(s_hlt),
    .fault(s_flt), .retired(s_ret));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int unsigned model_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected strobes/selects for a state code, straight from the output table.
  function automatic logic [14:0] exp_outs(input int st, input logic [5:0] op,
                                           input logic rdy, input logic z);
    logic mreq, mwe, irw, pcw, rw, rdst, m2r, hlt, flt;
    logic [1:0] pcs, asb, aop;
    {mreq, mwe, irw, pcw, rw, rdst, m2r, hlt, flt} = '0;
    pcs = 2'd0; asb = 2'd0; aop = 2'd0;
    case (st)
      0: begin mreq = 1; asb = 2'd1; if (rdy) begin irw = 1; pcw = 1; end end
      1: begin asb = 2'd3; if (op == OP_J) begin pcw = 1; pcs = 2'd2; end end
      2: begin
        if (op == OP_R) aop = 2'b10;
        else if (op == OP_BEQ) begin aop = 2'b01; pcs = 2'd1; pcw = z; end
        else asb = 2'd2;
      end
      3: begin mreq = 1; mwe = (op == OP_SW); end
      4: begin rw = 1; rdst = (op == OP_R); m2r = (op == OP_LW); end
      5: hlt = 1;
      6: flt = 1;
      default: ;
    endcase
    return {mreq, mwe, irw, pcw, rw, rdst, m2r, pcs, asb, aop, hlt, flt};
  endfunction

  function automatic bit retires(input logic [5:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

  // Builds the expected state trace of one instruction from its class and
  // the chosen wait counts, then plays it cycle by cycle.
  task automatic run_instr(input logic [5:0] op, input logic z, input int w_if,
                           input int w_mem, input bit stuck);
    int st_q[$];
    bit rdy_q[$];
    int unsigned exp_sat;
    for (int i = 0; i < w_if; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
    st_q.push_back(0); rdy_q.push_back(1'b1);
    st_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (op == OP_R || op == OP_ADDI || op == OP_BEQ || op == OP_LW || op == OP_SW) begin
      st_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
    end
    if (op == OP_LW || op == OP_SW) begin
      if (stuck) begin
        for (int i = 0; i <= TMO; i++) begin st_q.push_back(3); rdy_q.push_back(1'b0); end
      end else begin
        for (int i = 0; i < w_mem; i++) begin st_q.push_back(3); rdy_q.push_back(1'b0); end
        st_q.push_back(3); rdy_q.push_back(1'b1);
      end
    end
    if (!stuck && (op == OP_R || op == OP_ADDI || op == OP_LW)) begin
      st_q.push_back(4); rdy_q.push_back(1'($urandom_range(0, 1)));
    end
    if (stuck || op == OP_HALT || !retires(op)) begin
      for (int i = 0; i < 3; i++) begin
        st_q.push_back((op == OP_HALT) ? 5 : 6);
        rdy_q.push_back(stuck ? 1'b0 : 1'($urandom_range(0, 1)));
      end
    end
    for (int i = 0; i < st_q.size(); i++) begin
      mem_ready = rdy_q[i];
      zero = z;
      opcode = (st_q[i] == 0) ? 6'($urandom) : op;
      #1;
      chk("state", {29'd0, m_state}, st_q[i]);
      chk("outs", {17'd0, m_outs}, {17'd0, exp_outs(st_q[i], op, rdy_q[i], z)});
      if (stuck && st_q[i] == 6) chk("nt_stays_mem", {29'd0, n_state}, 32'd3);
      @(negedge clk);
    end
    if (retires(op) && !stuck && model_ret != 32'hffff_ffff) model_ret++;
    exp_sat = (model_ret > 7) ? 7 : model_ret;
    #1;
    chk("retired", m_ret, model_ret);
    chk("ret_sat", {29'd0, s_ret}, exp_sat);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rst_state", {29'd0, m_state}, 32'd0);
    chk("rst_ret", m_ret, 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    model_ret = 0;
  endtask

  logic [5:0] ops [6];

  initial begin
    ops[0] = OP_R; ops[1] = OP_ADDI; ops[2] = OP_LW;
    ops[3] = OP_SW; ops[4] = OP_BEQ; ops[5] = OP_J;
    Reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0; zero = 1'b0; model_ret = 0;
    #12;
    chk("rst_state", {29'd0, m_state}, 32'd0);
    chk("rst_outs", {17'd0, m_outs}, {17'd0, exp_outs(0, OP_R, 1'b0, 1'b0)});
    chk("rst_ret", m_ret, 32'd0);
    chk("rst_sat_ret", {29'd0, s_ret}, 32'd0);
    @(negedge clk);
    Reset = 1'b0;

    // short program with memory always ready
    run_instr(OP_ADDI, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LW,   1'b0, 0, 0, 1'b0);
    run_instr(OP_SW,   1'b0, 0, 0, 1'b0);
    run_instr(OP_BEQ,  1'b1, 0, 0, 1'b0);
    run_instr(OP_J,    1'b0, 0, 0, 1'b0);
    run_instr(OP_HALT, 1'b0, 0, 0, 1'b0);
    chk("prog_halted", {31'd0, m_hlt}, 32'd1);
    chk("prog_ret", m_ret, 32'd5);

    do_reset();
    run_instr(OP_R,   1'b0, 3, 0, 1'b0);
    run_instr(OP_BEQ, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LW,  1'b0, 0, TMO, 1'b0);
    run_instr(OP_SW,  1'b1, TMO, 2, 1'b0);
    repeat (9) run_instr(OP_J, 1'b0, 0, 0, 1'b0);
    chk("sat_at_7", {29'd0, s_ret}, 32'd7);
    for (int k = 0; k < 60; k++)
      run_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

    do_reset();
    run_instr(OP_ILL, 1'b0, 0, 0, 1'b0);
    chk("ill_fault", {31'd0, m_flt}, 32'd1);

    do_reset();
    run_instr(OP_LW, 1'b0, 0, 0, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    chk("tmo_err_hold", {29'd0, m_state}, 32'd6);
    chk("nt_mem_hold", {29'd0, n_state}, 32'd3);

    // asynchronous reset in the middle of a sw memory access
    do_reset();
    run_instr(OP_ADDI, 1'b0, 0, 0, 1'b0);
    run_instr(OP_J,    1'b0, 0, 0, 1'b0);
    opcode = OP_SW; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_state", {29'd0, m_state}, 32'd3);
    chk("mid_we", {31'd0, m_mwe}, 32'd1);
    @(negedge clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("arst_we", {31'd0, m_mwe}, 32'd0);
    chk("arst_state", {29'd0, m_state}, 32'd0);
    chk("arst_ret", m_ret, 32'd0);
    chk("arst_mreq", {31'd0, m_mreq}, 32'd1);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
